br_unit: RTL
============

// Module: br_unit
// PURPOSE
//  Registered branch/jump resolution unit with integrated branch history table (BHT).
//  Resolves conditional branches and JALR in EX, flags mispredictions and produces
//  the redirect target one cycle later. Trains 2-bit saturating counters and
//  serves fetch-stage predictions. Parametrised over XLEN; counts branches and misses.
// PARAMETERS
//  XLEN        64     datapath / address width (32 or 64)
//  BHT_ENTRIES 64     number of 2-bit counters; power of 2, >= 2
//  BHT_INIT    2'b01  counter value after reset (weakly not-taken)
//  CNT_W       32     width of performance counters
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  stall        in   1          hold all state; no capture, no BHT update, no counting
//  flush        in   1          discard current input; out_valid=0 next cycle
//  in_valid     in   1          EX slot holds a valid instruction
//  pc           in   XLEN       PC of EX instruction
//  ir           in   32         EX instruction word
//  r1, r2       in   XLEN       rs1 / rs2 operand values
//  pr_taken     in   1          prediction carried down the pipe for this instruction
//  pred_pc      in   XLEN       fetch PC for BHT lookup
//  pred_taken   out  1          combinational BHT prediction for pred_pc (counter[1])
//  out_valid    out  1          registered outputs below are valid
//  pr_miss      out  1          conditional branch mispredicted
//  jalr_taken   out  1          instruction was JALR
//  redirect     out  1          pr_miss | jalr_taken
//  redirect_addr out XLEN       correct next PC when redirect=1
//  br_cnt       out  CNT_W      resolved conditional branches
//  miss_cnt     out  CNT_W      mispredicted conditional branches
// BEHAVIOUR
//  - Reset: out_valid, pr_miss, jalr_taken, redirect=0; redirect_addr=0; br_cnt=miss_cnt=0;
//    all BHT counters=BHT_INIT. Reset wins over stall and flush.
//  - Capture (fire) = in_valid & ~stall & ~flush. Latency 1: outputs registered at edge.
//  - stall=1: outputs, BHT, counters hold; flush ignored while stall=1.
//  - flush=1 & ~stall: out_valid<=0, other outputs <=0; no BHT update, no count.
//  - ~fire & ~stall & ~flush (bubble): out_valid<=0, flags<=0.
//  - Branch: ir[6:0]=1100011. funct3 ir[14:12]: 000 EQ, 001 NE, 100 LT signed,
//    101 GE signed, 110 LTU, 111 GEU; 010/011 -> not taken, and not counted/trained.
//  - Branch target = pc + sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}); fall-through
//    = pc + 4; all sums mod 2^XLEN.
//  - pr_miss = branch & (taken != pr_taken); redirect_addr = taken ? target : pc+4.
//  - JALR: ir[6:0]=1100111: jalr_taken=1, redirect_addr = (r1 + sext(ir[31:20])) & ~1.
//  - Other opcodes: captured with all flags 0, redirect_addr=0.
//  - BHT index = pc[IDX+1:2], IDX=$clog2(BHT_ENTRIES); same mapping for pred_pc.
//  - BHT update on fire of valid-funct3 branch: taken -> sat-inc (max 3),
//    not taken -> sat-dec (min 0).
//  - Lookup of an index being written same cycle returns pre-edge value.
//  - br_cnt +1 per trained branch; miss_cnt +1 when also pr_miss; both wrap at 2^CNT_W.
// TESTING
//  1 rst, then pred_pc any -> pred_taken=0 (BHT_INIT=01); all outputs 0, counters 0.
//  2 BEQ pc=0x1000, imm=+16, r1=r2=5, pr_taken=0 -> next cycle out_valid=1, pr_miss=1,
//    redirect_addr=0x1010; br_cnt=1, miss_cnt=1; BHT[0x1000>>2 & 63] = 2'b10.
//  3 BLT r1=-1, r2=1 taken vs BLTU same operands not taken; pr_taken=1 ->
//    BLT pr_miss=0, BLTU pr_miss=1, redirect_addr=pc+4.
//  4 JALR r1=0x2003, imm=-2 -> jalr_taken=1, redirect=1, redirect_addr=0x2000;
//    counters unchanged.
//  5 Same branch taken 4x -> counter saturates at 3; then not-taken once -> 2, pred_taken=1.
//  6 stall=1 with branch held 3 cycles -> outputs/counters frozen; flush=1 with
//    valid branch -> out_valid=0, BHT and counters unchanged; XLEN=32 wrap:
//    pc=0xFFFFFFFC not-taken -> redirect_addr=0x0.

Source files
------------

// File: rtl/br_unit.sv
// Branch/JALR resolution unit: resolves in EX, registers redirect info one cycle later,
// trains a table of 2-bit saturating counters and serves fetch-side predictions.
module br_unit #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  BHT_INIT    = 2'b01,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      ir_i,
  input  logic [XLEN-1:0]  r1_i,
  input  logic [XLEN-1:0]  r2_i,
  input  logic             pr_taken_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  output logic             out_valid_o,
  output logic             pr_miss_o,
  output logic             jalr_taken_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_addr_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_br, is_jalr, f3_ok, taken_d, pr_miss_d, train, fire;
  logic [XLEN-1:0] br_imm, jalr_imm, br_target, fall_thru, jalr_sum, addr_d;
  logic [IDX-1:0]  upd_idx, pred_idx;
  logic [1:0]      upd_cur;

  logic            out_valid_q, pr_miss_q, jalr_q;
  logic [XLEN-1:0] redirect_addr_q;
  logic [CNT_W-1:0] br_cnt_q, miss_cnt_q;
  logic [1:0]      bht_q [BHT_ENTRIES];

  // Bits of the instruction word and fetch PC that never feed any logic here.
  logic unused_bits;
  assign unused_bits = ^{ir_i[19:15], pred_pc_i[XLEN-1:IDX+2], pred_pc_i[1:0]};

  assign opcode    = ir_i[6:0];
  assign funct3    = ir_i[14:12];
  assign is_br     = (opcode == 7'b1100011);
  assign is_jalr   = (opcode == 7'b1100111);
  assign f3_ok     = (funct3[2:1] != 2'b01);
  assign fire      = in_valid_i & ~stall_i & ~flush_i;
  assign train     = fire & is_br & f3_ok;

  assign br_imm    = {{(XLEN-12){ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
  assign jalr_imm  = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
  assign br_target = pc_i + br_imm;
  assign fall_thru = pc_i + XLEN'(4);
  assign jalr_sum  = r1_i + jalr_imm;

  always_comb begin
    taken_d = 1'b0;
    case (funct3)
      3'b000:  taken_d = (r1_i == r2_i);
      3'b001:  taken_d = (r1_i != r2_i);
      3'b100:  taken_d = ($signed(r1_i) <  $signed(r2_i));
      3'b101:  taken_d = ($signed(r1_i) >= $signed(r2_i));
      3'b110:  taken_d = (r1_i <  r2_i);
      3'b111:  taken_d = (r1_i >= r2_i);
      default: taken_d = 1'b0;
    endcase
  end

  always_comb begin
    addr_d    = '0;
    pr_miss_d = 1'b0;
    if (is_br) begin
      pr_miss_d = (taken_d != pr_taken_i);
      addr_d    = taken_d ? br_target : fall_thru;
    end else if (is_jalr) begin
      addr_d    = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q     <= 1'b0;
      pr_miss_q       <= 1'b0;
      jalr_q          <= 1'b0;
      redirect_addr_q <= '0;
      br_cnt_q        <= '0;
      miss_cnt_q      <= '0;
    end else if (!stall_i) begin
      // Flush and bubbles both fall out of fire=0: everything cleared, nothing counted.
      out_valid_q     <= fire;
      pr_miss_q       <= fire & pr_miss_d;
      jalr_q          <= fire & is_jalr;
      redirect_addr_q <= fire ? addr_d : '0;
      if (train) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (pr_miss_d) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign upd_idx = pc_i[IDX+1:2];
  assign upd_cur = bht_q[upd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_INIT;
    end else if (train) begin
      if (taken_d && upd_cur != 2'b11)       bht_q[upd_idx] <= upd_cur + 2'd1;
      else if (!taken_d && upd_cur != 2'b00) bht_q[upd_idx] <= upd_cur - 2'd1;
    end
  end

  // Read straight from the array, so a same-cycle update is not visible until after the edge.
  assign pred_idx     = pred_pc_i[IDX+1:2];
  assign pred_taken_o = bht_q[pred_idx][1];

  assign out_valid_o     = out_valid_q;
  assign pr_miss_o       = pr_miss_q;
  assign jalr_taken_o    = jalr_q;
  assign redirect_o      = pr_miss_q | jalr_q;
  assign redirect_addr_o = redirect_addr_q;
  assign br_cnt_o        = br_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule
